// File: rtl/wb_cp0_regfile.sv
// CP0 register file for the writeback stage: Status/Cause/EPC/Count/Compare,
// exception and eret redirect, and interrupt-pending generation.
module wb_cp0_regfile #(
   parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_rdc,
   input  logic [31:0] cp0_data,
   input  logic        ex_wb,
   input  logic        eret_flush,
   input  logic        branch_delay_wb,
   input  logic [31:0] pc,
   input  logic [4:0]  ex_code,
   input  logic [5:0]  ext_int,
   output logic [31:0] cp0_rdata,
   output logic [31:0] epc_out,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic        int_pending,
   output logic        status_exl
);

   logic        tick_q,    tick_d;
   logic [31:0] count_q,   count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q,      ti_d;
   logic [5:0]  iphw_q,    iphw_d;
   logic [1:0]  ipsw_q,    ipsw_d;
   logic        bd_q,      bd_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q,     epc_d;
   logic [7:0]  im_q,      im_d;
   logic        exl_q,     exl_d;
   logic        ie_q,      ie_d;

   logic        wr;
   logic [31:0] status_rd;
   logic [31:0] cause_rd;

   assign flush    = ex_wb | eret_flush;
   assign flush_pc = ex_wb ? EX_ENTRY : epc_q;
   assign wr       = cp0_we & ~flush;

   assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause_rd  = {bd_q, ti_q, 14'b0, iphw_q, ipsw_q, 1'b0, exccode_q, 2'b0};

   assign epc_out     = epc_q;
   assign status_exl  = exl_q;
   assign int_pending = (|({iphw_q, ipsw_q} & im_q)) & ie_q & ~exl_q;

   always_comb begin
      cp0_rdata = '0;
      case (cp0_rdc)
         5'd9:    cp0_rdata = count_q;
         5'd11:   cp0_rdata = compare_q;
         5'd12:   cp0_rdata = status_rd;
         5'd13:   cp0_rdata = cause_rd;
         5'd14:   cp0_rdata = epc_q;
         default: cp0_rdata = '0;
      endcase
   end

   always_comb begin
      tick_d    = ~tick_q;
      count_d   = tick_q ? count_q + 32'd1 : count_q;
      compare_d = compare_q;
      ti_d      = ti_q | (count_q == compare_q);
      iphw_d    = {ext_int[5] | ti_q, ext_int[4:0]};
      ipsw_d    = ipsw_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;

      // Count/Compare writes live outside the flush priority chain below,
      // but still rely on wr, which is already gated by flush.
      if (wr && cp0_rdc == 5'd9)
         count_d = cp0_data;
      if (wr && cp0_rdc == 5'd11) begin
         compare_d = cp0_data;
         ti_d      = 1'b0;
      end

      if (ex_wb) begin
         exl_d     = 1'b1;
         exccode_d = ex_code;
         if (!exl_q) begin
            epc_d = branch_delay_wb ? pc - 32'd4 : pc;
            bd_d  = branch_delay_wb;
         end
      end else if (eret_flush) begin
         exl_d = 1'b0;
      end else if (wr) begin
         case (cp0_rdc)
            5'd12: begin
               im_d  = cp0_data[15:8];
               exl_d = cp0_data[1];
               ie_d  = cp0_data[0];
            end
            5'd13:   ipsw_d = cp0_data[9:8];
            5'd14:   epc_d  = cp0_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tick_q    <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
         iphw_q    <= '0;
         ipsw_q    <= '0;
         bd_q      <= 1'b0;
         exccode_q <= '0;
         epc_q     <= '0;
         im_q      <= '0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
      end else begin
         tick_q    <= tick_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
         iphw_q    <= iphw_d;
         ipsw_q    <= ipsw_d;
         bd_q      <= bd_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
      end
   end

endmodule

// File: tb/tb_wb_cp0_regfile.sv
// Directed bench for wb_cp0_regfile with a word-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_wb_cp0_regfile;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cp0_we;
   logic [4:0]  cp0_rdc;
   logic [31:0] cp0_data;
   logic        ex_wb;
   logic        eret_flush;
   logic        branch_delay_wb;
   logic [31:0] pc;
   logic [4:0]  ex_code;
   logic [5:0]  ext_int;
   logic [31:0] cp0_rdata;
   logic [31:0] epc_out;
   logic        flush;
   logic [31:0] flush_pc;
   logic        int_pending;
   logic        status_exl;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
   logic        m_tick;

   wb_cp0_regfile #(.EX_ENTRY(32'hBFC0_0380)) dut (
      .clk(clk), .resetn(resetn), .cp0_we(cp0_we), .cp0_rdc(cp0_rdc),
      .cp0_data(cp0_data), .ex_wb(ex_wb), .eret_flush(eret_flush),
      .branch_delay_wb(branch_delay_wb), .pc(pc), .ex_code(ex_code),
      .ext_int(ext_int), .cp0_rdata(cp0_rdata), .epc_out(epc_out),
      .flush(flush), .flush_pc(flush_pc), .int_pending(int_pending),
      .status_exl(status_exl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] r);
      case (r)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic m_int();
      return (|(m_cause[15:8] & m_status[15:8])) && m_status[0] && !m_status[1];
   endfunction

   // Reference model: whole-word registers updated from architectural rules.
   always @(posedge clk) begin : model_upd
      logic        w;
      logic [31:0] oc, ocmp;
      logic        oti, oexl;
      if (!resetn) begin
         m_status = 32'h0040_0000; m_cause = 0; m_epc = 0;
         m_count = 0; m_compare = 0; m_tick = 0;
      end else begin
         w    = cp0_we && !ex_wb && !eret_flush;
         oc   = m_count;  ocmp = m_compare;
         oti  = m_cause[30]; oexl = m_status[1];
         m_cause[15:10] = {ext_int[5] | oti, ext_int[4:0]};
         if (w && cp0_rdc == 9) m_count = cp0_data;
         else if (m_tick)       m_count = oc + 1;
         m_tick = !m_tick;
         if (w && cp0_rdc == 11) begin
            m_compare = cp0_data; m_cause[30] = 0;
         end else if (oc == ocmp) m_cause[30] = 1;
         if (ex_wb) begin
            if (!oexl) begin
               m_epc = branch_delay_wb ? pc - 32'd4 : pc;
               m_cause[31] = branch_delay_wb;
            end
            m_status[1] = 1; m_cause[6:2] = ex_code;
         end else if (eret_flush) m_status[1] = 0;
         else if (w) begin
            case (cp0_rdc)
               5'd12: m_status = (m_status & ~32'h0000_FF03) | (cp0_data & 32'h0000_FF03);
               5'd13: m_cause  = (m_cause  & ~32'h0000_0300) | (cp0_data & 32'h0000_0300);
               5'd14: m_epc    = cp0_data;
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rdata",       cp0_rdata, m_read(cp0_rdc));
         chk("epc_out",     epc_out, m_epc);
         chk("status_exl",  {31'b0, status_exl}, {31'b0, m_status[1]});
         chk("int_pending", {31'b0, int_pending}, {31'b0, m_int()});
         chk("flush",       {31'b0, flush}, {31'b0, ex_wb | eret_flush});
         chk("flush_pc",    flush_pc, ex_wb ? 32'hBFC0_0380 : m_epc);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      cp0_we = 1'b1; cp0_rdc = r; cp0_data = d;
      cyc();
      cp0_we = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] r, input logic [31:0] exp);
      cp0_rdc = r; #1;
      chk(nm, cp0_rdata, exp);
   endtask

   initial begin
      int n;
      resetn = 0; cp0_we = 0; cp0_rdc = 0; cp0_data = 0; ex_wb = 0;
      eret_flush = 0; branch_delay_wb = 0; pc = 0; ex_code = 0; ext_int = 0;
      cyc(); cyc();
      chk_en = 1'b1;

      rd_chk("rst_status", 5'd12, 32'h0040_0000);
      rd_chk("rst_cause",  5'd13, 32'h0);
      rd_chk("rst_epc",    5'd14, 32'h0);
      chk("rst_int", {31'b0, int_pending}, 32'h0);

      // leave reset with Compare parked far away so TI stays clear
      resetn = 1; mtc0(5'd11, 32'hFFFF_FFFF);

      ex_wb = 1; pc = 32'hBFC0_1000; branch_delay_wb = 1; ex_code = 5'h08; #1;
      chk("ex_flush_pc", flush_pc, 32'hBFC0_0380);
      chk("ex_flush", {31'b0, flush}, 32'h1);
      cyc();
      ex_wb = 0; branch_delay_wb = 0;
      rd_chk("ex_epc",   5'd14, 32'hBFC0_0FFC);
      rd_chk("ex_cause", 5'd13, 32'h8000_0020);
      chk("ex_exl", {31'b0, status_exl}, 32'h1);

      ex_wb = 1; pc = 32'h100; ex_code = 5'h0C;
      cyc();
      ex_wb = 0;
      rd_chk("ex2_epc", 5'd14, 32'hBFC0_0FFC);

      eret_flush = 1; #1;
      chk("eret_flush_pc", flush_pc, 32'hBFC0_0FFC);
      cyc();
      eret_flush = 0; #1;
      chk("eret_exl", {31'b0, status_exl}, 32'h0);

      mtc0(5'd12, 32'h0);
      cp0_we = 1; cp0_rdc = 5'd12; cp0_data = 32'hFFFF_FFFF; ex_wb = 1; pc = 32'h200; ex_code = 0;
      cyc();
      cp0_we = 0; ex_wb = 0;
      rd_chk("st_suppr", 5'd12, 32'h0040_0002);
      eret_flush = 1; cyc(); eret_flush = 0;
      mtc0(5'd12, 32'hFFFF_FFFF);
      rd_chk("st_mask", 5'd12, 32'h0040_FF03);
      mtc0(5'd12, 32'h0);

      mtc0(5'd9, 32'h0);
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h0040_8001);
      cp0_rdc = 5'd13; #1;
      n = 2;
      while (cp0_rdata[30] == 1'b0 && n < 40) begin
         cyc(); n++;
      end
      chk("ti_latency_ok", {31'b0, (n == 10 || n == 11)}, 32'h1);
      chk("ti_int_lag", {31'b0, int_pending}, 32'h0);
      cyc();
      chk("ti_int", {31'b0, int_pending}, 32'h1);
      mtc0(5'd11, 32'd100);
      cp0_rdc = 5'd13; #1;
      chk("ti_clr", {31'b0, cp0_rdata[30]}, 32'h0);
      cyc();
      chk("ti_int_clr", {31'b0, int_pending}, 32'h0);
      mtc0(5'd11, 32'hFFFF_FFFF);

      mtc0(5'd12, 32'h0040_0401);
      ext_int = 6'b000001; #1;
      chk("ext_pre", {31'b0, int_pending}, 32'h0);
      cyc();
      rd_chk("ext_ip2", 5'd13, 32'h0000_0400 | (cp0_rdata & 32'h8000_007C));
      chk("ext_int", {31'b0, int_pending}, 32'h1);
      ext_int = 0; cyc(); cyc();
      mtc0(5'd13, 32'h0000_0100);
      cp0_rdc = 5'd13; #1;
      chk("sw_ip0", cp0_rdata & 32'h0000_0300, 32'h0000_0100);
      chk("sw_int", {31'b0, int_pending}, 32'h0);

      mtc0(5'd11, 32'd2);
      mtc0(5'd9, 32'd0);
      repeat (8) cyc();
      ex_wb = 1; pc = 32'h300; cyc(); ex_wb = 0;
      cp0_rdc = 5'd13; #1;
      chk("pre_rst_ti", {31'b0, cp0_rdata[30]}, 32'h1);
      resetn = 0; cyc();
      rd_chk("mid_status", 5'd12, 32'h0040_0000);
      rd_chk("mid_cause",  5'd13, 32'h0);
      rd_chk("mid_count",  5'd9,  32'h0);
      chk("mid_exl", {31'b0, status_exl}, 32'h0);
      resetn = 1; mtc0(5'd11, 32'hFFFF_FFFF);
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
